// File: rtl/dir_rom_scan.sv
// dir_rom_scan: walks a SCAN_ROWS x SCAN_COLS window of a combinational
// direction ROM in row-major order and streams each entry out with its
// row/column position over a valid/ready interface.
//
// Optional feature: define DIR_SCAN_OOB_EN to add the out_oob output, which
// flags samples whose signed offset exceeds +7.
//
// Handshake: a sample transfers on a rising edge where out_valid && out_ready.
// Once out_valid is high, out_row/out_col/out_off/out_last (and out_oob) stay
// unchanged until that transfer happens. out_ready may toggle freely.
module dir_rom_scan #(
    parameter int SCAN_ROWS = 16,
    parameter int SCAN_COLS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic [7:0] rom_addr,
    input  logic [4:0] rom_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_row,
    output logic [3:0] out_col,
    output logic [4:0] out_off,
    output logic       out_last,
`ifdef DIR_SCAN_OOB_EN
    output logic       out_oob,
`endif
    output logic       done,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [3:0] ROW_MAX = 4'(SCAN_ROWS - 1);
    localparam logic [3:0] COL_MAX = 4'(SCAN_COLS - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] row;
    logic [3:0] col;
    logic       load;
    logic       last_pos;
    logic       finish;

    assign busy      = (state != IDLE);
    assign rom_addr  = {row, col};
    assign dbg_state = state;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus the load/finish strobes used by the datapath.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        finish     = 1'b0;
        last_pos   = (row == ROW_MAX) && (col == COL_MAX);
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                // The output register is free when empty or being drained now.
                load = !out_valid || out_ready;
                if (load && last_pos) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (out_valid && out_ready && out_last) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Row/column counters; cleared on start and on window completion so the
    // ROM address sits at 8'h00 whenever the block is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= 4'd0;
            col <= 4'd0;
        end else if (state == IDLE && start) begin
            row <= 4'd0;
            col <= 4'd0;
        end else if (load && !last_pos) begin
            if (col == COL_MAX) begin
                col <= 4'd0;
                row <= row + 4'd1;
            end else begin
                col <= col + 4'd1;
            end
        end else if (finish) begin
            row <= 4'd0;
            col <= 4'd0;
        end
    end

    // Output sample register and the one-cycle done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_row   <= 4'd0;
            out_col   <= 4'd0;
            out_off   <= 5'd0;
            out_last  <= 1'b0;
`ifdef DIR_SCAN_OOB_EN
            out_oob   <= 1'b0;
`endif
            done      <= 1'b0;
        end else begin
            done <= finish;
            if (load) begin
                out_valid <= 1'b1;
                out_row   <= row;
                out_col   <= col;
                out_off   <= rom_data;
                out_last  <= last_pos;
`ifdef DIR_SCAN_OOB_EN
                // Positive offsets +8..+15 fall outside the legal range.
                out_oob   <= !rom_data[4] && rom_data[3];
`endif
            end else if (finish) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dir_rom_scan.sv
// Bench for dir_rom_scan: a full 16x16 instance and a 2x3 instance share the
// clock and reset; each has its own ROM model built from rom_f.
module tb_dir_rom_scan;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       busy;
    logic [7:0] rom_addr;
    logic [4:0] rom_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_row;
    logic [3:0] out_col;
    logic [4:0] out_off;
    logic       out_last;
    logic       done;
    logic [1:0] dbg_state;
`ifdef DIR_SCAN_OOB_EN
    logic       out_oob;
    logic       s_out_oob;
`endif

    logic       s_start;
    logic       s_busy;
    logic [7:0] s_rom_addr;
    logic [4:0] s_rom_data;
    logic       s_out_valid;
    logic       s_out_ready;
    logic [3:0] s_out_row;
    logic [3:0] s_out_col;
    logic [4:0] s_out_off;
    logic       s_out_last;
    logic       s_done;
    logic [1:0] s_dbg_state;

    int n_checks;
    int n_fail;
    logic [12:0] exp_q[$];

    // Direction table: pinned entries plus a scrambled fill for the rest.
    function automatic logic [4:0] rom_f(input logic [7:0] a);
        case (a)
            8'h00:   return 5'h06;
            8'hff:   return 5'h1a;
            8'h60:   return 5'h08;
            8'h08:   return 5'h1f;
            default: return 5'((5'(a[7:4]) * 5'd7) ^ (5'(a[3:0]) * 5'd3));
        endcase
    endfunction

    assign rom_data   = rom_f(rom_addr);
    assign s_rom_data = rom_f(s_rom_addr);

    dir_rom_scan u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_col(out_col), .out_off(out_off),
        .out_last(out_last),
`ifdef DIR_SCAN_OOB_EN
        .out_oob(out_oob),
`endif
        .done(done), .dbg_state(dbg_state)
    );

    dir_rom_scan #(.SCAN_ROWS(2), .SCAN_COLS(3)) u_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .busy(s_busy),
        .rom_addr(s_rom_addr), .rom_data(s_rom_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_row(s_out_row), .out_col(s_out_col), .out_off(s_out_off),
        .out_last(s_out_last),
`ifdef DIR_SCAN_OOB_EN
        .out_oob(s_out_oob),
`endif
        .done(s_done), .dbg_state(s_dbg_state)
    );

    // Clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_addr"}, rom_addr, 0);
        check({tag, "_rowcol"}, {out_row, out_col}, 0);
        check({tag, "_off"}, out_off, 0);
        check({tag, "_last_done"}, {out_last, done}, 0);
        check({tag, "_state"}, dbg_state, 0);
    endtask

    // Full-window scan on the 16x16 instance. rnd: random out_ready;
    // restart_at: pulse start once after that many accepts (-1 = never);
    // abort_at: assert reset after that many accepts (-1 = never).
    task automatic scan_a(input bit rnd, input int restart_at, input int abort_at);
        int got_n, done_n, last_cyc, cyc;
        bit stalled, fin, pulsed;
        logic [14:0] held;
        logic [12:0] exp;
        exp_q.delete();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                exp_q.push_back({4'(r), 4'(c), rom_f(8'(r * 16 + c))});
        got_n = 0; done_n = 0; last_cyc = 0;
        stalled = 0; fin = 0; pulsed = 0; held = '0;
        @(negedge clk);
        start = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("lat_n1_valid", out_valid, 0);
        check("lat_busy", busy, 1);
        check("lat_addr0", rom_addr, 0);
        for (cyc = 1; cyc <= 3000 && !fin; cyc++) begin
            @(negedge clk);
            if (cyc == 1) check("lat_n2_valid", out_valid, 1);
            if (stalled) check("stall_hold", {out_valid, out_row, out_col, out_off, out_last}, held);
            if (done) begin
                done_n++;
                check("done_timing", cyc, last_cyc + 1);
                fin = (got_n == 256);
            end
            start = 1'b0;
            if (restart_at >= 0 && got_n == restart_at && !pulsed) begin
                start = 1'b1;
                pulsed = 1'b1;
            end
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_sample", 1, 0);
                end else begin
                    exp = exp_q.pop_front();
                    check("sample", {out_row, out_col, out_off}, exp);
                    check("last_flag", out_last, (got_n == 255));
`ifdef DIR_SCAN_OOB_EN
                    check("oob", out_oob, (exp[4:0] >= 5'h08 && exp[4:0] <= 5'h0f));
`endif
                end
                got_n++;
                last_cyc = cyc;
            end
            stalled = out_valid && !out_ready;
            held = {out_valid, out_row, out_col, out_off, out_last};
            if (abort_at > 0 && got_n == abort_at) begin
                #2 rst_n = 1'b0;
                #1 check_all_zero("abort");
                @(negedge clk);
                rst_n = 1'b1;
                start = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("abort_no_done", {done, busy}, 0);
                end
                return;
            end
        end
        start = 1'b0;
        check("all_samples", got_n, 256);
        check("one_done", done_n, 1);
        if (!rnd) check("no_bubbles", last_cyc, 256);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("idle_after", {busy, out_valid, rom_addr}, 0);
    endtask

    // 2x3 window on the small instance with out_ready held high.
    task automatic scan_b();
        int got_n, done_n;
        logic [7:0] exp_addr[$];
        logic [7:0] a;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 3; c++)
                exp_addr.push_back({4'(r), 4'(c)});
        got_n = 0; done_n = 0;
        @(negedge clk);
        s_start = 1'b1;
        s_out_ready = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (s_done) done_n++;
            if (s_out_valid && s_out_ready) begin
                if (exp_addr.size() == 0) begin
                    check("small_extra", 1, 0);
                end else begin
                    a = exp_addr.pop_front();
                    check("small_addr", {s_out_row, s_out_col}, a);
                    check("small_off", s_out_off, rom_f(a));
                    check("small_last", s_out_last, (a == 8'h12));
                end
                got_n++;
            end
        end
        check("small_count", got_n, 6);
        check("small_done", done_n, 1);
        check("small_idle", s_busy, 0);
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst_n = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
        s_start = 1'b0;
        s_out_ready = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset");

        scan_a(1'b0, -1, -1);   // full-rate scan, latency and no bubbles
        scan_a(1'b1, -1, -1);   // random backpressure
        scan_a(1'b0, 10, -1);   // start while busy is ignored
        scan_a(1'b1, -1, 100);  // reset mid-scan
        scan_a(1'b0, -1, -1);   // restarts from address 0
        scan_b();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dir_rom_scan.md
DIR_ROM_SCAN -- requirements
Module: dir_rom_scan

Interface
REQ-001 SHALL have parameter SCAN_ROWS, default 16, number of window rows scanned (legal 1..16).
REQ-002 SHALL have parameter SCAN_COLS, default 16, number of window columns scanned (legal 1..16).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a window scan.
REQ-006 SHALL have port busy  output  1  high while a scan is in progress.
REQ-007 SHALL have port rom_addr  output  8  address to direction ROM, {row[3:0], col[3:0]}.
REQ-008 SHALL have port rom_data  input  5  combinational ROM data for rom_addr, two's-complement signed offset.
REQ-009 SHALL have port out_valid  output  1  output sample valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts sample.
REQ-011 SHALL have port out_row  output  4  row of current sample.
REQ-012 SHALL have port out_col  output  4  column of current sample.
REQ-013 SHALL have port out_off  output  5  signed offset captured from rom_data.
REQ-014 SHALL have port out_last  output  1  marks final sample of the window.
REQ-015 SHALL have port done  output  1  one-cycle pulse when final sample is accepted.

Function
REQ-016 SHALL implement FSM states IDLE, SCAN, DRAIN; busy = (state != IDLE).
REQ-017 IDLE: start=1 -> SCAN next cycle, row/col counters cleared to 0; rom_addr held at 8'h00 in IDLE.
REQ-018 SHALL drive rom_addr directly from registered row/col counters, never combinationally from inputs.
REQ-019 SCAN: "load" = (!out_valid || out_ready); on load, register rom_data, row, col into out_off/out_row/out_col and set out_valid=1.
REQ-020 On load, col increments; col==SCAN_COLS-1 wraps col to 0 and increments row.
REQ-021 Load at row==SCAN_ROWS-1, col==SCAN_COLS-1 SHALL set out_last=1 and transition SCAN -> DRAIN; counters hold.
REQ-022 DRAIN: out_valid && out_ready && out_last -> IDLE, out_valid=0, out_last=0, done=1 for exactly one cycle.
REQ-023 out_valid=1 and out_ready=0 SHALL hold out_row/out_col/out_off/out_last stable and stall counters.
REQ-024 Latency: start accepted in cycle N -> out_valid=1 in cycle N+2 with rom_addr 8'h00 data.
REQ-025 Throughput: out_ready held high -> one sample per cycle, SCAN_ROWS*SCAN_COLS samples total, no bubbles.
REQ-026 start while busy=1 SHALL be ignored (no restart, no queueing).
REQ-027 out_valid SHALL deassert after a non-last accept only if no load occurs that cycle (cannot happen in SCAN).
REQ-028 Sample order: row-major, col fastest; out_off equals ROM content at {out_row,out_col}.

Reset
REQ-029 rst_n=0 SHALL asynchronously force state=IDLE, row=col=0, rom_addr=0, out_valid=0, out_last=0, done=0, busy=0, out_row=out_col=0, out_off=0.
REQ-030 Reset mid-scan SHALL abandon the window; no done pulse; first start after release scans from address 0.

Configuration
REQ-031 Macro DIR_SCAN_OOB_EN defined: add output out_oob (1 bit), registered with the sample, high when out_off signed value > 7 (5'h08..5'h0f); meaningful only when out_valid=1, reset 0.
REQ-032 DIR_SCAN_OOB_EN undefined: no out_oob port, no related logic; all other behaviour identical.

Verification
REQ-033 Reset then start, out_ready=1, ROM model = direction table -> out_valid at N+2, first sample row0 col0 off 5'h06, 256th sample row15 col15 off 5'h1a with out_last=1, done one cycle later.
REQ-034 out_ready toggled 1/0 pseudo-randomly -> all 256 samples delivered in order, no loss/duplication, outputs stable while stalled.
REQ-035 SCAN_ROWS=2, SCAN_COLS=3 -> exactly 6 samples, addresses 00,01,02,10,11,12, out_last on 8'h12 sample.
REQ-036 start pulsed at sample 10 of a scan -> ignored, total still 256 samples, one done pulse.
REQ-037 rst_n low at sample 100 (async, mid-cycle) -> outputs zero immediately; new start yields sample row0 col0 off 5'h06.
REQ-038 DIR_SCAN_OOB_EN defined -> sample at address 8'h60 (off 5'h08) out_oob=1; address 8'h08 (off 5'h1f) out_oob=0.
